// File: rtl/alu_core.sv
// Registered ALU with operand-pairing wait FSM, 16-cycle operand timeout and clock enable.
// Results and status flags update only on completing cycles and otherwise hold.
module alu_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             mode,
  input  logic [3:0]       cmd,
  input  logic [1:0]       inp_valid,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cin,
  output logic [WIDTH:0]   res,
  output logic             cout,
  output logic             oflow,
  output logic             g,
  output logic             l,
  output logic             e,
  output logic             err
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_WAIT_A, S_WAIT_B} state_t;

  typedef struct packed {
    logic [WIDTH:0] res;
    logic           cout;
    logic           oflow;
    logic           g;
    logic           l;
    logic           e;
    logic           err;
  } result_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_mode;
  logic [3:0]       r_cmd;
  logic             r_cin;

  function automatic logic is_legal(input logic m, input logic [3:0] c);
    return m ? (c <= 4'd8) : (c <= 4'd13);
  endfunction

  function automatic logic is_a_only(input logic m, input logic [3:0] c);
    return m ? (c == 4'd4 || c == 4'd5) : (c == 4'd6 || c == 4'd8 || c == 4'd9);
  endfunction

  function automatic logic is_b_only(input logic m, input logic [3:0] c);
    return m ? (c == 4'd6 || c == 4'd7) : (c == 4'd7 || c == 4'd10 || c == 4'd11);
  endfunction

  function automatic result_t err_result();
    result_t r;
    r     = '0;
    r.err = 1'b1;
    return r;
  endfunction

  function automatic result_t compute(input logic m, input logic [3:0] c,
                                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic ci);
    result_t          r;
    logic [WIDTH:0]   ax, bx, cx;
    logic [WIDTH-1:0] rol, ror;
    int               amt;
    r   = '0;
    ax  = {1'b0, a};
    bx  = {1'b0, b};
    cx  = {{WIDTH{1'b0}}, ci};
    amt = {{(32-SH_W){1'b0}}, b[SH_W-1:0]};
    rol = (a << amt) | (a >> (WIDTH - amt));
    ror = (a >> amt) | (a << (WIDTH - amt));
    if (m) begin
      case (c)
        4'd0: begin r.res = ax + bx;       r.cout  = r.res[WIDTH];       end
        4'd1: begin r.res = ax - bx;       r.oflow = (ax < bx);          end
        4'd2: begin r.res = ax + bx + cx;  r.cout  = r.res[WIDTH];       end
        4'd3: begin r.res = ax - bx - cx;  r.oflow = (ax < (bx + cx));   end
        4'd4: begin r.res = ax + ONE_X;    r.cout  = r.res[WIDTH];       end
        4'd5: begin r.res = ax - ONE_X;    r.oflow = (a == '0);          end
        4'd6: begin r.res = bx + ONE_X;    r.cout  = r.res[WIDTH];       end
        4'd7: begin r.res = bx - ONE_X;    r.oflow = (b == '0);          end
        4'd8: begin r.g = (a > b); r.l = (a < b); r.e = (a == b);       end
        default: r.err = 1'b1;
      endcase
    end else begin
      case (c)
        4'd0:  r.res = {1'b0, a & b};
        4'd1:  r.res = {1'b0, ~(a & b)};
        4'd2:  r.res = {1'b0, a | b};
        4'd3:  r.res = {1'b0, ~(a | b)};
        4'd4:  r.res = {1'b0, a ^ b};
        4'd5:  r.res = {1'b0, ~(a ^ b)};
        4'd6:  r.res = {1'b0, ~a};
        4'd7:  r.res = {1'b0, ~b};
        4'd8:  r.res = {1'b0, a >> 1};
        4'd9:  r.res = {1'b0, a << 1};
        4'd10: r.res = {1'b0, b >> 1};
        4'd11: r.res = {1'b0, b << 1};
        4'd12: begin r.res = {1'b0, rol}; r.err = |b[WIDTH-1:SH_W]; end
        4'd13: begin r.res = {1'b0, ror}; r.err = |b[WIDTH-1:SH_W]; end
        default: r.err = 1'b1;
      endcase
    end
    return r;
  endfunction

  // While waiting, the latched half of the command context replaces the live inputs.
  result_t w_idle_res;
  result_t w_wa_res;
  result_t w_wb_res;

  always_comb begin
    w_idle_res = compute(mode, cmd, opa, opb, cin);
    w_wa_res   = compute(r_mode, r_cmd, opa, r_opb, r_cin);
    w_wb_res   = compute(r_mode, r_cmd, r_opa, opb, r_cin);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_mode  <= 1'b0;
      r_cmd   <= '0;
      r_cin   <= 1'b0;
      {res, cout, oflow, g, l, e, err} <= '0;
    end else if (ce) begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!is_legal(mode, cmd) || inp_valid == 2'b00) begin
            {res, cout, oflow, g, l, e, err} <= err_result();
          end else if (is_a_only(mode, cmd)) begin
            {res, cout, oflow, g, l, e, err} <= inp_valid[0] ? w_idle_res : err_result();
          end else if (is_b_only(mode, cmd)) begin
            {res, cout, oflow, g, l, e, err} <= inp_valid[1] ? w_idle_res : err_result();
          end else if (inp_valid == 2'b11) begin
            {res, cout, oflow, g, l, e, err} <= w_idle_res;
          end else begin
            r_mode <= mode;
            r_cmd  <= cmd;
            r_cin  <= cin;
            if (inp_valid[0]) begin
              r_opa   <= opa;
              r_state <= S_WAIT_B;
            end else begin
              r_opb   <= opb;
              r_state <= S_WAIT_A;
            end
          end
        end
        S_WAIT_A, S_WAIT_B: begin
          if ((r_state == S_WAIT_A) ? inp_valid[0] : inp_valid[1]) begin
            {res, cout, oflow, g, l, e, err} <= (r_state == S_WAIT_A) ? w_wa_res : w_wb_res;
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == 4'd15) begin
            {res, cout, oflow, g, l, e, err} <= err_result();
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Directed table-driven bench for alu_core (WIDTH=8) plus split-operand, timeout,
// clock-enable and mid-wait reset sequences.
module tb_alu_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       mode;
  logic [3:0] cmd;
  logic [1:0] inp_valid;
  logic [7:0] opa, opb;
  logic       cin;
  logic [8:0] res;
  logic       cout, oflow, g, l, e, err;

  int n_cmp = 0;
  int n_bad = 0;

  alu_core #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode), .cmd(cmd), .inp_valid(inp_valid),
    .opa(opa), .opb(opb), .cin(cin), .res(res), .cout(cout), .oflow(oflow),
    .g(g), .l(l), .e(e), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mode;
    logic [3:0] cmd;
    logic [1:0] iv;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] res;
    logic       co, of, eg, el, ee, er;
  } vec_t;

  localparam int NV = 20;
  vec_t v[NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic [3:0] c, input logic [1:0] iv,
                       input logic [7:0] a, input logic [7:0] b, input logic ci);
    mode = m; cmd = c; inp_valid = iv; opa = a; opb = b; cin = ci;
  endtask

  task automatic chk(input string name, input logic [8:0] xr, input logic xco, input logic xof,
                     input logic xg, input logic xl, input logic xe, input logic xer);
    n_cmp++;
    if ({res, cout, oflow, g, l, e, err} !== {xr, xco, xof, xg, xl, xe, xer}) begin
      n_bad++;
      $display("FAIL %s: got res=%h co=%b of=%b g=%b l=%b e=%b err=%b, want res=%h co=%b of=%b g=%b l=%b e=%b err=%b",
               name, res, cout, oflow, g, l, e, err, xr, xco, xof, xg, xl, xe, xer);
    end
  endtask

  initial begin
    //            mode  cmd    iv     a      b      cin   res      co    of    g     l     e     err
    v[0]  = '{1'b1, 4'd0,  2'b11, 8'hFF, 8'h01, 1'b0, 9'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    v[1]  = '{1'b1, 4'd1,  2'b11, 8'h05, 8'h07, 1'b0, 9'h1FE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    v[2]  = '{1'b1, 4'd8,  2'b11, 8'h05, 8'h07, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    v[3]  = '{1'b0, 4'd12, 2'b11, 8'h81, 8'h01, 1'b0, 9'h003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    v[4]  = '{1'b0, 4'd12, 2'b11, 8'h81, 8'h11, 1'b0, 9'h003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    v[5]  = '{1'b1, 4'd2,  2'b11, 8'h10, 8'h20, 1'b1, 9'h031, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    v[6]  = '{1'b1, 4'd3,  2'b11, 8'h10, 8'h10, 1'b1, 9'h1FF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    v[7]  = '{1'b1, 4'd4,  2'b01, 8'hFF, 8'h00, 1'b0, 9'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    v[8]  = '{1'b1, 4'd7,  2'b10, 8'h00, 8'h00, 1'b0, 9'h1FF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    v[9]  = '{1'b0, 4'd1,  2'b11, 8'hF0, 8'h3C, 1'b0, 9'h0CF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    v[10] = '{1'b0, 4'd5,  2'b11, 8'hF0, 8'h3C, 1'b0, 9'h033, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    v[11] = '{1'b0, 4'd9,  2'b01, 8'h81, 8'h00, 1'b0, 9'h002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    v[12] = '{1'b0, 4'd13, 2'b11, 8'h81, 8'h01, 1'b0, 9'h0C0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    v[13] = '{1'b1, 4'd9,  2'b11, 8'h12, 8'h34, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    v[14] = '{1'b0, 4'd14, 2'b11, 8'h12, 8'h34, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    v[15] = '{1'b1, 4'd0,  2'b00, 8'h12, 8'h34, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    v[16] = '{1'b1, 4'd4,  2'b10, 8'h12, 8'h34, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    v[17] = '{1'b1, 4'd8,  2'b11, 8'h07, 8'h05, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    v[18] = '{1'b1, 4'd8,  2'b11, 8'h05, 8'h05, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    v[19] = '{1'b0, 4'd10, 2'b10, 8'h00, 8'h81, 1'b0, 9'h040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b0; ce = 1'b1;
    drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
    step(); step();
    chk("reset", 9'h000, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      drive(v[i].mode, v[i].cmd, v[i].iv, v[i].a, v[i].b, v[i].cin);
      step();
      chk($sformatf("vec%0d", i), v[i].res, v[i].co, v[i].of, v[i].eg, v[i].el, v[i].ee, v[i].er);
    end

    // Split operands: opa first, unrelated cmd while waiting, opb later.
    drive(1'b1, 4'd0, 2'b01, 8'h10, 8'hEE, 1'b0);
    step();
    chk("split_hold", 9'h040, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd5, 2'b00, 8'h99, 8'h99, 1'b1);
      step();
    end
    chk("split_wait", 9'h040, 0, 0, 0, 0, 0, 0);
    drive(1'b0, 4'd5, 2'b10, 8'h99, 8'h20, 1'b1);
    step();
    chk("split_done", 9'h030, 0, 0, 0, 0, 0, 0);

    // opb first, opa later (WAIT_A path), SUB with latched opb.
    drive(1'b1, 4'd1, 2'b10, 8'h00, 8'h03, 1'b0);
    step();
    drive(1'b0, 4'd0, 2'b01, 8'h05, 8'hFF, 1'b1);
    step();
    chk("waita_sub", 9'h002, 0, 0, 0, 0, 0, 0);

    // inp_valid=11 while waiting keeps the latched opa.
    drive(1'b1, 4'd0, 2'b01, 8'h01, 8'h00, 1'b0);
    step();
    drive(1'b1, 4'd0, 2'b11, 8'h50, 8'h02, 1'b0);
    step();
    chk("iv11_wait", 9'h003, 0, 0, 0, 0, 0, 0);

    // Timeout: 20 waiting cycles, 4 of them with ce=0 -> 16 counted.
    drive(1'b1, 4'd0, 2'b01, 8'h11, 8'h00, 1'b0);
    step();
    for (int i = 0; i < 20; i++) begin
      ce = (i % 5 == 2) ? 1'b0 : 1'b1;
      inp_valid = 2'b00;
      step();
      if (i == 18) chk("timeout_early", 9'h003, 0, 0, 0, 0, 0, 0);
    end
    ce = 1'b1;
    chk("timeout_err", 9'h000, 0, 0, 0, 0, 0, 1);

    // ce=0 with fresh operands: everything holds.
    drive(1'b1, 4'd0, 2'b11, 8'h01, 8'h01, 1'b0);
    ce = 1'b0;
    step(); step();
    chk("ce_hold", 9'h000, 0, 0, 0, 0, 0, 1);
    ce = 1'b1;
    step();
    chk("ce_resume", 9'h002, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset while in WAIT_B.
    drive(1'b1, 4'd0, 2'b01, 8'h07, 8'h00, 1'b0);
    step();
    #2 rst = 1'b0;
    #1;
    chk("async_rst", 9'h000, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    drive(1'b1, 4'd0, 2'b10, 8'h00, 8'h03, 1'b0);
    step();
    chk("post_rst_wait", 9'h000, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 4'd0, 2'b01, 8'h02, 8'h00, 1'b0);
    step();
    chk("post_rst_done", 9'h005, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
